// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive decoder: FSM states,
// decoded line states and the CRC16 constants with a bit-serial step helper.
package usb_rx_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, RECEIVE, EOP1, EOP2, ERR} rx_state_t;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // One wire bit into the left-shifting CRC16 register
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_rx_decoder_if.sv
// Line inputs and decoded-byte outputs of the USB receive decoder.
// USB_RX_CRC16_EN adds the crc_error flag.
interface usb_rx_decoder_if;
  logic       d_plus;
  logic       d_minus;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_active;
  logic       rx_eop;
  logic       rx_error;
`ifdef USB_RX_CRC16_EN
  logic       crc_error;

  modport master (input d_plus, d_minus,
                  output rx_data, rx_data_valid, rx_active, rx_eop, rx_error, crc_error);
  modport slave  (output d_plus, d_minus,
                  input rx_data, rx_data_valid, rx_active, rx_eop, rx_error, crc_error);
`else
  modport master (input d_plus, d_minus,
                  output rx_data, rx_data_valid, rx_active, rx_eop, rx_error);
  modport slave  (output d_plus, d_minus,
                  input rx_data, rx_data_valid, rx_active, rx_eop, rx_error);
`endif
endinterface

// File: rtl/usb_rx_sampler.sv
// Synchronises D+/D-, tracks bit phase from line transitions and strobes
// the held line state at mid-bit.
module usb_rx_sampler
  import usb_rx_pkg::*;
#(
  parameter int BIT_PERIOD = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic       strobe,
  output logic [1:0] line
);
  localparam int PW = $clog2(BIT_PERIOD);

  logic [1:0]    dp_sync, dm_sync;
  logic [1:0]    line_now, line_q;
  logic [PW-1:0] phase;

  // 11 is not a legal differential state; it is folded into SE0
  assign line_now = (dp_sync[1] ^ dm_sync[1]) ? {dp_sync[1], dm_sync[1]} : LINE_SE0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_sync <= 2'b11;
      dm_sync <= 2'b00;
      line_q  <= LINE_J;
      phase   <= '0;
    end else begin
      dp_sync <= {dp_sync[0], d_plus};
      dm_sync <= {dm_sync[0], d_minus};
      line_q  <= line_now;
      if (line_now != line_q || phase == PW'(BIT_PERIOD - 1))
        phase <= '0;
      else
        phase <= phase + 1'b1;
    end
  end

  assign strobe = (phase == PW'(BIT_PERIOD / 2));
  assign line   = line_q;

endmodule

// File: rtl/usb_rx_decoder.sv
// USB receive decoder: NRZI decode, bit unstuffing, SYNC/EOP framing and
// byte assembly. Define USB_RX_CRC16_EN for DATA-packet CRC16 checking.
module usb_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int         BIT_PERIOD  = 8,
  parameter logic [7:0] SYNC_BYTE   = 8'h80,
  parameter int         STUFF_LIMIT = 6
) (
  input logic               clk,
  input logic               n_rst,
  usb_rx_decoder_if.master  bus
);
  localparam int OW = $clog2(STUFF_LIMIT + 1);

  rx_state_t     state, state_n;
  logic          strobe;
  logic [1:0]    line, prev_line;
  logic [7:0]    shift, shift_nx;
  logic [2:0]    bit_cnt;
  logic [OW-1:0] ones_cnt;
  logic          j_cnt, eop_ok;
  logic          eop_p, err_p, valid_p;
  logic [7:0]    rx_data_q;
  logic          valid_q, active_q, eop_q, err_q;

  usb_rx_sampler #(.BIT_PERIOD(BIT_PERIOD)) u_sampler (
    .clk    (clk),
    .n_rst  (n_rst),
    .d_plus (bus.d_plus),
    .d_minus(bus.d_minus),
    .strobe (strobe),
    .line   (line)
  );

  logic is_se0, is_j, is_k, nrzi_bit, in_pkt, data_stb, stuff_slot;
  logic bit_take, stuff_err, byte_done;
  assign is_se0     = (line == LINE_SE0);
  assign is_j       = (line == LINE_J);
  assign is_k       = (line == LINE_K);
  assign nrzi_bit   = (line == prev_line);
  assign in_pkt     = (state == SYNC) || (state == RECEIVE);
  assign data_stb   = strobe && !is_se0;
  assign stuff_slot = (ones_cnt == OW'(STUFF_LIMIT));
  // A bit enters the shifter on the SYNC-opening K or any non-stuff slot
  assign bit_take   = data_stb && (((state == IDLE) && is_k) || (in_pkt && !stuff_slot));
  assign stuff_err  = data_stb && in_pkt && stuff_slot && nrzi_bit;
  assign byte_done  = bit_take && in_pkt && (bit_cnt == 3'd7);
  assign shift_nx   = {nrzi_bit, shift[7:1]};

  always_comb begin
    state_n = state;
    eop_p   = 1'b0;
    err_p   = 1'b0;
    valid_p = 1'b0;
    case (state)
      IDLE:    if (strobe && is_k) state_n = SYNC;
      SYNC:    if ((strobe && is_se0) || stuff_err) state_n = ERR;
               else if (byte_done) state_n = (shift_nx == SYNC_BYTE) ? RECEIVE : ERR;
      RECEIVE: if (strobe && is_se0) state_n = EOP1;
               else if (stuff_err)   state_n = ERR;
               else if (byte_done)   valid_p = 1'b1;
      EOP1:    if (strobe) state_n = is_se0 ? EOP2 : ERR;
      EOP2:    if (strobe && is_j) begin
                 state_n = IDLE;
                 eop_p   = eop_ok;
                 err_p   = !eop_ok;
               end else if (strobe && is_k) state_n = ERR;
      ERR:     if (strobe && is_j && j_cnt) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n == ERR && state != ERR) err_p = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      prev_line <= LINE_J;
      shift     <= '0;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      j_cnt     <= 1'b0;
      eop_ok    <= 1'b0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_n;
      if (data_stb) prev_line <= line;
      if (bit_take) begin
        shift    <= shift_nx;
        bit_cnt  <= (state == IDLE) ? 3'd1 : bit_cnt + 3'd1;
        ones_cnt <= nrzi_bit ? ones_cnt + 1'b1 : '0;
      end else if (data_stb && in_pkt && stuff_slot) begin
        ones_cnt <= '0;
      end
      if (state == RECEIVE && strobe && is_se0) eop_ok <= (bit_cnt == 3'd0);
      j_cnt <= (state == ERR) ? (strobe ? is_j : j_cnt) : 1'b0;
      if (valid_p) rx_data_q <= shift_nx;
      valid_q  <= valid_p;
      eop_q    <= eop_p;
      err_q    <= err_p;
      active_q <= (state_n == RECEIVE) || (state_n == EOP1) || (state_n == EOP2);
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_data_valid = valid_q;
  assign bus.rx_active     = active_q;
  assign bus.rx_eop        = eop_q;
  assign bus.rx_error      = err_q;

`ifdef USB_RX_CRC16_EN
  logic [15:0] crc;
  logic        pid_seen, pid_is_data, crc_err_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc         <= CRC16_INIT;
      pid_seen    <= 1'b0;
      pid_is_data <= 1'b0;
      crc_err_q   <= 1'b0;
    end else begin
      if (state == SYNC) begin
        crc      <= CRC16_INIT;
        pid_seen <= 1'b0;
      end else if (state == RECEIVE && bit_take) begin
        if (pid_seen) crc <= crc16_step(crc, nrzi_bit);
        if (byte_done && !pid_seen) begin
          pid_seen    <= 1'b1;
          pid_is_data <= (shift_nx[1:0] == 2'b11);
        end
      end
      crc_err_q <= eop_p && pid_is_data && (crc != CRC16_RESIDUAL);
    end
  end

  assign bus.crc_error = crc_err_q;
`endif

endmodule
